// File: rtl/scr_base_l3_params_pkg.sv
// rtl/scr_base_l3_params_pkg.sv - shared L3 bank parameters and victim-buffer types
package scr_base_l3_params_pkg;

    localparam int SCR_BASE_L3_BANK_VB_DEPTH       = 16;
    localparam int SCR_BASE_L3_BANK_VB_PTR_SIZE    = $clog2(SCR_BASE_L3_BANK_VB_DEPTH);
    localparam int SCR_BASE_L3_BANK_ROB_ADDR_WIDTH = 20;
    localparam int SCR_BASE_L3_BANK_DBUFF_PTR_SIZE = 4;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } vb_state_e;

    typedef struct packed {
        logic [SCR_BASE_L3_BANK_ROB_ADDR_WIDTH-1:0] addr;
        logic [SCR_BASE_L3_BANK_DBUFF_PTR_SIZE-1:0] dbuf;
    } vb_entry_t;

endpackage

// File: rtl/scr_base_l3_bank_vb_ctrl_if.sv
// rtl/scr_base_l3_bank_vb_ctrl_if.sv - victim-buffer alloc/lookup/writeback/ack bundle
interface scr_base_l3_bank_vb_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DBUF_W = 4,
    parameter int PTR_W  = 4
);
    logic              alloc_vld;
    logic              alloc_rdy;
    logic [ADDR_W-1:0] alloc_addr;
    logic [DBUF_W-1:0] alloc_dbuf;
    logic [PTR_W-1:0]  alloc_idx;
    logic [ADDR_W-1:0] lkp_addr;
    logic              lkp_hit;
    logic [PTR_W-1:0]  lkp_idx;
    logic              wb_vld;
    logic              wb_rdy;
    logic [ADDR_W-1:0] wb_addr;
    logic [DBUF_W-1:0] wb_dbuf;
    logic [PTR_W-1:0]  wb_idx;
    logic              ack_vld;
    logic [PTR_W-1:0]  ack_idx;

    // Environment side: bank pipeline plus memory write channel
    modport master (
        output alloc_vld, alloc_addr, alloc_dbuf, lkp_addr, wb_rdy, ack_vld, ack_idx,
        input  alloc_rdy, alloc_idx, lkp_hit, lkp_idx, wb_vld, wb_addr, wb_dbuf, wb_idx
    );

    // Controller side
    modport slave (
        input  alloc_vld, alloc_addr, alloc_dbuf, lkp_addr, wb_rdy, ack_vld, ack_idx,
        output alloc_rdy, alloc_idx, lkp_hit, lkp_idx, wb_vld, wb_addr, wb_dbuf, wb_idx
    );
endinterface

// File: rtl/scr_base_l3_vb_ord_fifo.sv
// rtl/scr_base_l3_vb_ord_fifo.sv - allocation-order index FIFO with wrapping pointers
module scr_base_l3_vb_ord_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [PTR_W-1:0] push_idx,
    input  logic             pop,
    output logic             empty,
    output logic [PTR_W-1:0] head
);
    logic [PTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    // Pointer and fill-count update; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Index storage; contents are meaningless until pushed so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_idx;
    end

    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/scr_base_l3_bank_vb_ctrl.sv
// rtl/scr_base_l3_bank_vb_ctrl.sv - L3 bank victim-buffer controller (perf counters under SCR_BASE_L3_VB_PERF_EN)
module scr_base_l3_bank_vb_ctrl
    import scr_base_l3_params_pkg::*;
#(
    parameter int VB_DEPTH = SCR_BASE_L3_BANK_VB_DEPTH,
    parameter int ADDR_W   = SCR_BASE_L3_BANK_ROB_ADDR_WIDTH,
    parameter int DBUF_W   = SCR_BASE_L3_BANK_DBUFF_PTR_SIZE,
    localparam int PTR_W   = $clog2(VB_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    scr_base_l3_bank_vb_ctrl_if.slave      vb,
    output logic [PTR_W:0]                 occ,
    output logic [31:0]                    perf_alloc,
    output logic [31:0]                    perf_stall,
    output logic [31:0]                    perf_lkp_hit
);
    vb_state_e         state_q [VB_DEPTH];
    vb_state_e         state_d [VB_DEPTH];
    logic [ADDR_W-1:0] addr_q  [VB_DEPTH];
    logic [DBUF_W-1:0] dbuf_q  [VB_DEPTH];
    logic [PTR_W:0]    occ_q;

    logic              alloc_fire;
    logic              wb_fire;
    logic              ack_ok;
    logic              ord_empty;
    logic [PTR_W-1:0]  ord_head;
    logic [PTR_W-1:0]  free_idx;
    logic              lkp_multi;
    logic              alloc_dup;

    // Entry state register; reset forgets every in-flight line at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VB_DEPTH; i++) state_q[i] <= FREE;
        end else begin
            for (int i = 0; i < VB_DEPTH; i++) state_q[i] <= state_d[i];
        end
    end

    // Next-state: alloc, writeback issue and ack always touch distinct entries
    always_comb begin
        for (int i = 0; i < VB_DEPTH; i++) state_d[i] = state_q[i];
        if (alloc_fire) state_d[free_idx] = PEND;
        if (wb_fire)    state_d[ord_head] = ISSUED;
        if (ack_ok)     state_d[vb.ack_idx] = FREE;
    end

    // Outputs: lowest-free priority encoder and lowest-match CAM over live entries
    always_comb begin
        free_idx    = '0;
        vb.lkp_hit  = 1'b0;
        vb.lkp_idx  = '0;
        lkp_multi   = 1'b0;
        alloc_dup   = 1'b0;
        for (int i = VB_DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) free_idx = PTR_W'(i);
        end
        for (int i = 0; i < VB_DEPTH; i++) begin
            if (state_q[i] != FREE && addr_q[i] == vb.lkp_addr) begin
                if (vb.lkp_hit) lkp_multi = 1'b1;
                else begin
                    vb.lkp_hit = 1'b1;
                    vb.lkp_idx = PTR_W'(i);
                end
            end
            if (state_q[i] != FREE && addr_q[i] == vb.alloc_addr) alloc_dup = 1'b1;
        end
    end

    // Entry payload captured on the alloc handshake
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            addr_q[free_idx] <= vb.alloc_addr;
            dbuf_q[free_idx] <= vb.alloc_dbuf;
        end
    end

    // Occupancy moves by alloc minus ack; an ack never opens a slot in its own cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_q + {{PTR_W{1'b0}}, alloc_fire} - {{PTR_W{1'b0}}, ack_ok};
    end

    assign vb.alloc_rdy = (occ_q != (PTR_W+1)'(VB_DEPTH));
    assign vb.alloc_idx = free_idx;
    assign alloc_fire   = vb.alloc_vld && vb.alloc_rdy;
    assign ack_ok       = vb.ack_vld && (state_q[vb.ack_idx] == ISSUED);
    assign vb.wb_vld    = !ord_empty;
    assign vb.wb_idx    = ord_head;
    assign vb.wb_addr   = addr_q[ord_head];
    assign vb.wb_dbuf   = dbuf_q[ord_head];
    assign wb_fire      = vb.wb_vld && vb.wb_rdy;
    assign occ          = occ_q;

    scr_base_l3_vb_ord_fifo #(
        .DEPTH (VB_DEPTH),
        .PTR_W (PTR_W)
    ) u_ord_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (alloc_fire),
        .push_idx (free_idx),
        .pop      (wb_fire),
        .empty    (ord_empty),
        .head     (ord_head)
    );

`ifdef SCR_BASE_L3_VB_PERF_EN
    logic [31:0] perf_alloc_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_lkp_hit_q;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_alloc_q   <= '0;
            perf_stall_q   <= '0;
            perf_lkp_hit_q <= '0;
        end else begin
            if (alloc_fire && perf_alloc_q != '1) perf_alloc_q <= perf_alloc_q + 32'd1;
            if (vb.alloc_vld && !vb.alloc_rdy && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
            if (vb.lkp_hit && perf_lkp_hit_q != '1) perf_lkp_hit_q <= perf_lkp_hit_q + 32'd1;
        end
    end

    assign perf_alloc   = perf_alloc_q;
    assign perf_stall   = perf_stall_q;
    assign perf_lkp_hit = perf_lkp_hit_q;
`else
    assign perf_alloc   = '0;
    assign perf_stall   = '0;
    assign perf_lkp_hit = '0;
`endif

    a_ack_to_issued: assert property (@(posedge clk) disable iff (!rst_n)
        vb.ack_vld |-> (state_q[vb.ack_idx] == ISSUED));
    a_lkp_unique: assert property (@(posedge clk) disable iff (!rst_n) !lkp_multi);
    a_alloc_unique: assert property (@(posedge clk) disable iff (!rst_n) alloc_fire |-> !alloc_dup);
endmodule

// File: tb/tb_scr_base_l3_bank_vb_ctrl.sv
// tb/tb_scr_base_l3_bank_vb_ctrl.sv - scoreboard bench for the victim-buffer controller
module tb_scr_base_l3_bank_vb_ctrl;
    localparam int D  = 16;
    localparam int AW = 20;
    localparam int DW = 4;
    localparam int PW = 4;
`ifdef SCR_BASE_L3_VB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] dbuf;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [PW:0] occ;
    logic [31:0] perf_alloc, perf_stall, perf_lkp_hit;

    int n_checks = 0;
    int n_errors = 0;

    int            st    [D];
    logic [AW-1:0] maddr [D];
    wb_t           sb [$];
    int            m_alloc = 0;
    int            m_stall = 0;
    int            m_hit   = 0;

    scr_base_l3_bank_vb_ctrl_if #(.ADDR_W(AW), .DBUF_W(DW), .PTR_W(PW)) vb ();

    scr_base_l3_bank_vb_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vb           (vb.slave),
        .occ          (occ),
        .perf_alloc   (perf_alloc),
        .perf_stall   (perf_stall),
        .perf_lkp_hit (perf_lkp_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) st[i] = 0;
        sb.delete();
        m_alloc = 0;
        m_stall = 0;
        m_hit   = 0;
    endtask

    // One clock: check combinational/registered outputs against the model, then advance both
    task automatic cycle();
        int  cnt;
        int  lo_free;
        int  hit_idx;
        bit  hit;
        bit  af, wf, ak;
        int  a_idx;
        #1;
        cnt = 0;
        lo_free = -1;
        hit = 0;
        hit_idx = 0;
        for (int i = 0; i < D; i++) begin
            if (st[i] != 0) cnt++;
            else if (lo_free < 0) lo_free = i;
            if (st[i] != 0 && maddr[i] == vb.lkp_addr && !hit) begin
                hit = 1;
                hit_idx = i;
            end
        end
        chk("occ", 32'(occ), 32'(cnt));
        chk("alloc_rdy", 32'(vb.alloc_rdy), 32'(cnt != D));
        if (vb.alloc_vld && cnt != D) chk("alloc_idx", 32'(vb.alloc_idx), 32'(lo_free));
        chk("lkp_hit", 32'(vb.lkp_hit), 32'(hit));
        chk("lkp_idx", 32'(vb.lkp_idx), 32'(hit_idx));
        chk("wb_vld", 32'(vb.wb_vld), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("wb_idx", 32'(vb.wb_idx), 32'(sb[0].idx));
            chk("wb_addr", 32'(vb.wb_addr), 32'(sb[0].addr));
            chk("wb_dbuf", 32'(vb.wb_dbuf), 32'(sb[0].dbuf));
        end
        af = vb.alloc_vld && (cnt != D);
        wf = vb.wb_rdy && (sb.size() != 0);
        ak = vb.ack_vld && (st[vb.ack_idx] == 2);
        a_idx = int'(vb.ack_idx);
        if (vb.alloc_vld && cnt == D) m_stall++;
        if (hit) m_hit++;
        @(posedge clk);
        if (ak) st[a_idx] = 0;
        if (wf) begin
            st[sb[0].idx] = 2;
            void'(sb.pop_front());
        end
        if (af) begin
            wb_t e;
            st[lo_free] = 1;
            maddr[lo_free] = vb.alloc_addr;
            e.idx = lo_free;
            e.addr = vb.alloc_addr;
            e.dbuf = vb.alloc_dbuf;
            sb.push_back(e);
            m_alloc++;
        end
        @(negedge clk);
    endtask

    initial begin
        vb.alloc_vld  = 1'b0;
        vb.alloc_addr = '0;
        vb.alloc_dbuf = '0;
        vb.lkp_addr   = '0;
        vb.wb_rdy     = 1'b0;
        vb.ack_vld    = 1'b0;
        vb.ack_idx    = '0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_alloc_rdy", 32'(vb.alloc_rdy), 32'd1);
        chk("rst_wb_vld", 32'(vb.wb_vld), 32'd0);
        chk("rst_lkp_hit", 32'(vb.lkp_hit), 32'd0);
        chk("rst_perf_alloc", perf_alloc, 32'd0);
        rst_n = 1'b1;

        // Single alloc, writeback appears one cycle later
        vb.alloc_vld = 1'b1; vb.alloc_addr = 20'h100; vb.alloc_dbuf = 4'd3;
        #1 chk("t1_alloc_idx", 32'(vb.alloc_idx), 32'd0);
        cycle();
        vb.alloc_vld = 1'b0;
        chk("t1_wb_vld", 32'(vb.wb_vld), 32'd1);
        chk("t1_wb_addr", 32'(vb.wb_addr), 32'h100);
        chk("t1_wb_idx", 32'(vb.wb_idx), 32'd0);
        chk("t1_occ", 32'(occ), 32'd1);
        vb.wb_rdy = 1'b1;
        cycle();
        vb.wb_rdy = 1'b0; vb.ack_vld = 1'b1; vb.ack_idx = 4'd0;
        cycle();
        vb.ack_vld = 1'b0;
        cycle();

        // Three allocs issued in order, acked out of order
        vb.wb_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vb.alloc_vld = 1'b1; vb.alloc_addr = 20'h300 + 20'(i); vb.alloc_dbuf = 4'(i + 8);
            cycle();
        end
        vb.alloc_vld = 1'b0;
        repeat (2) cycle();
        foreach (sb[i]) chk("t3_sb_drained", 32'd1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            int order [3] = '{2, 0, 1};
            vb.ack_vld = 1'b1; vb.ack_idx = 4'(order[k]);
            cycle();
        end
        vb.ack_vld = 1'b0;
        chk("t3_occ", 32'(occ), 32'd0);

        // Lookup visibility around alloc and ack
        vb.alloc_vld = 1'b1; vb.alloc_addr = 20'h200; vb.alloc_dbuf = 4'd5; vb.lkp_addr = 20'h200;
        #1 chk("t3_next_idx", 32'(vb.alloc_idx), 32'd0);
        chk("t5_hit_alloc_cyc", 32'(vb.lkp_hit), 32'd0);
        cycle();
        vb.alloc_vld = 1'b0;
        chk("t5_hit_next", 32'(vb.lkp_hit), 32'd1);
        chk("t5_idx_next", 32'(vb.lkp_idx), 32'd0);
        cycle();
        vb.ack_vld = 1'b1; vb.ack_idx = 4'd0;
        #1 chk("t5_hit_ack_cyc", 32'(vb.lkp_hit), 32'd1);
        cycle();
        vb.ack_vld = 1'b0;
        chk("t5_hit_after", 32'(vb.lkp_hit), 32'd0);
        vb.lkp_addr = 20'h0;

        // Fill all entries with writeback blocked, then stall for five cycles
        vb.wb_rdy = 1'b0;
        for (int i = 0; i < D; i++) begin
            vb.alloc_vld = 1'b1; vb.alloc_addr = 20'h1000 + 20'(i); vb.alloc_dbuf = 4'(i);
            cycle();
        end
        vb.alloc_addr = 20'h2000; vb.alloc_dbuf = 4'd7;
        repeat (5) cycle();
        vb.alloc_vld = 1'b0;
        chk("t2_occ", 32'(occ), 32'd16);
        chk("t2_alloc_rdy", 32'(vb.alloc_rdy), 32'd0);
        chk("t2_perf_stall", perf_stall, PERF ? 32'd5 : 32'd0);

        // Issue entries 0..4, then alloc while full together with ack of entry 4
        vb.wb_rdy = 1'b1;
        repeat (5) cycle();
        vb.wb_rdy = 1'b0;
        vb.alloc_vld = 1'b1; vb.ack_vld = 1'b1; vb.ack_idx = 4'd4;
        #1 chk("t4_rdy_ack_cyc", 32'(vb.alloc_rdy), 32'd0);
        cycle();
        vb.ack_vld = 1'b0;
        #1 chk("t4_rdy_next", 32'(vb.alloc_rdy), 32'd1);
        chk("t4_alloc_idx", 32'(vb.alloc_idx), 32'd4);
        cycle();
        vb.alloc_vld = 1'b0;
        chk("t4_occ", 32'(occ), 32'd16);
        chk("perf_alloc", perf_alloc, PERF ? 32'(m_alloc) : 32'd0);
        chk("perf_stall", perf_stall, PERF ? 32'(m_stall) : 32'd0);
        chk("perf_lkp_hit", perf_lkp_hit, PERF ? 32'(m_hit) : 32'd0);

        // Reset mid-operation with entries 0..3 issued
        rst_n = 1'b0;
        #1 chk("t6_occ", 32'(occ), 32'd0);
        chk("t6_wb_vld", 32'(vb.wb_vld), 32'd0);
        chk("t6_alloc_rdy", 32'(vb.alloc_rdy), 32'd1);
        chk("t6_perf_alloc", perf_alloc, 32'd0);
        model_clear();
        vb.ack_vld = 1'b1; vb.ack_idx = 4'd1;
        @(posedge clk);
        @(negedge clk);
        vb.ack_vld = 1'b0;
        rst_n = 1'b1;
        cycle();
        chk("t6_occ_after", 32'(occ), 32'd0);
        vb.alloc_vld = 1'b1; vb.alloc_addr = 20'h500; vb.alloc_dbuf = 4'd2;
        #1 chk("t6_alloc_idx", 32'(vb.alloc_idx), 32'd0);
        cycle();
        vb.alloc_vld = 1'b0; vb.wb_rdy = 1'b1;
        cycle();
        vb.wb_rdy = 1'b0; vb.ack_vld = 1'b1; vb.ack_idx = 4'd0;
        cycle();
        vb.ack_vld = 1'b0;
        cycle();
        chk("end_occ", 32'(occ), 32'd0);
        chk("end_perf_alloc", perf_alloc, PERF ? 32'(m_alloc) : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
